// File: rtl/cv32e40x_clmul_iter.sv
// rtl/cv32e40x_clmul_iter.sv - iterative carry-less multiplier (clmul/clmulh/clmulr), BITS_PER_CYCLE bits per step
// Optional: define CV32E40X_CLMUL_EARLY_EXIT_EN to finish as soon as the remaining multiplier bits are zero.
module cv32e40x_clmul_iter #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [1:0]      operator_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    input  logic            kill_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] result_o,
    output logic            busy_o
);

    localparam int N     = XLEN / BITS_PER_CYCLE;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        r_state;
    logic [2*XLEN-1:0] r_a;
    logic [XLEN-1:0]   r_b;
    logic [1:0]        r_op;
    logic [2*XLEN-1:0] r_acc;
    logic [CNT_W-1:0]  r_cnt;
    logic [XLEN-1:0]   r_result;

    logic [2*XLEN-1:0] w_acc_next;
    logic [XLEN-1:0]   w_b_next;
    logic [XLEN-1:0]   w_slice;
    logic              w_last;
    logic              w_accept;

    assign ready_o  = (r_state == S_IDLE) && !kill_i;
    assign valid_o  = (r_state == S_DONE);
    assign busy_o   = (r_state != S_IDLE);
    assign result_o = r_result;
    assign w_accept = valid_i && ready_o;
    assign w_b_next = r_b >> BITS_PER_CYCLE;

    // r_a is pre-shifted by the running base, so only the in-step offset j is applied here
    always_comb begin
        w_acc_next = r_acc;
        for (int j = 0; j < BITS_PER_CYCLE; j++) begin
            if (r_b[j]) begin
                w_acc_next = w_acc_next ^ (r_a << j);
            end
        end
    end

    always_comb begin
        case (r_op)
            2'b01:   w_slice = w_acc_next[2*XLEN-1 -: XLEN];
            2'b10:   w_slice = w_acc_next[2*XLEN-2 -: XLEN];
            default: w_slice = w_acc_next[XLEN-1:0];
        endcase
    end

`ifdef CV32E40X_CLMUL_EARLY_EXIT_EN
    assign w_last = (r_cnt == '0) || (w_b_next == '0);
`else
    assign w_last = (r_cnt == '0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else if (kill_i) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a     <= {{XLEN{1'b0}}, op_a_i};
                        r_b     <= op_b_i;
                        r_op    <= operator_i;
                        r_acc   <= '0;
                        r_cnt   <= CNT_W'(N - 1);
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_acc <= w_acc_next;
                    r_a   <= r_a << BITS_PER_CYCLE;
                    r_b   <= w_b_next;
                    if (w_last) begin
                        r_result <= w_slice;
                        r_state  <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_DONE: begin
                    if (ready_i) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/cv32e40x_clmul_iter.md
# cv32e40x_clmul_iter

Iterative, parametrised carry-less multiply unit for Zbc clmul, clmulh and clmulr. It sits beside the MUL/DIV units in EX. It is fed by the decoded mul operator and operands, and returns a registered result over a valid/ready handshake. The unit processes BITS_PER_CYCLE multiplier bits per cycle, which trades area for latency relative to a single-cycle array.

## Interface
- XLEN, 32: operand and result width; even, ≥ 8.
- BITS_PER_CYCLE, 4: multiplier bits consumed per CALC cycle; power of 2; divides XLEN.
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset. One clock domain; reset is asynchronous and active-low.
- valid_i  in  1  operation request.
- ready_o  out  1  unit can accept; high only in IDLE with kill_i low.
- operator_i  in  2  00 = clmul, 01 = clmulh, 10 = clmulr, 11 = treated as clmul.
- op_a_i  in  XLEN  multiplicand (rs1).
- op_b_i  in  XLEN  multiplier (rs2).
- kill_i  in  1  abort any in-flight operation.
- valid_o  out  1  result_o valid.
- ready_i  in  1  consumer takes result.
- result_o  out  XLEN  registered result.
- busy_o  out  1  state is CALC or DONE.

## Operation
- **Full product.** P is the 2·XLEN-bit value XOR over i of (op_a << i) for each set bit i of op_b. Bit 2·XLEN−1 is always 0.
- **Result by operator.**
  - clmul: P[XLEN−1:0].
  - clmulh: P[2·XLEN−1:XLEN].
  - clmulr: P[2·XLEN−2:XLEN−1].
- **FSM states:** IDLE, CALC, DONE.
- **IDLE.**
  - On valid_i && ready_o, capture op_a, op_b and operator.
  - Clear the 2·XLEN accumulator.
  - Load the iteration counter with XLEN/BITS_PER_CYCLE − 1.
  - Go to CALC.
- **CALC (each cycle).**
  - For j in 0..BITS_PER_CYCLE−1: if b_reg[j] is set, acc ^= a_reg << (base + j).
  - base advances by BITS_PER_CYCLE per cycle.
  - b_reg shifts right by BITS_PER_CYCLE.
  - When the counter is 0, register the selected result slice into result_o and go to DONE. Otherwise decrement the counter.
- **DONE.**
  - valid_o = 1 and result_o is held stable.
  - On ready_i, go to IDLE.
  - No acceptance in DONE; back-to-back operations pay one IDLE cycle.
- **kill_i.**
  - Forces IDLE at the next edge from any state.
  - valid_o drops at that edge; result_o keeps its last value.
  - kill_i with valid_i in IDLE: the request is not accepted (ready_o is low).
- **ready_i outside DONE:** ignored.
- **Operand changes after acceptance:** no effect.
- **Reset values:** state IDLE, ready_o = 1, valid_o = 0, busy_o = 0, result_o = 0, accumulator and counter = 0.
- **Reset mid-operation:** immediate return to reset values; the operation is lost.

## Timing
- Accept edge E0, then N = XLEN/BITS_PER_CYCLE CALC cycles.
- valid_o is high from the cycle after the last CALC cycle: N+1 cycles after the acceptance cycle. Defaults: N = 8, valid_o in cycle 9.
- valid_o stays high until the cycle after ready_i is sampled high.
- ready_o returns high one cycle after the DONE handshake.
- No combinational path from any input to result_o or valid_o.
- ready_o depends combinationally on kill_i only.

## Configuration
- **CV32E40X_CLMUL_EARLY_EXIT_EN defined:**
  - In CALC, if b_reg after this cycle's shift is zero, the result is finalised this cycle and the FSM goes to DONE.
  - CALC length = max(1, ceil((msb index of op_b + 1)/BITS_PER_CYCLE)).
  - op_b = 0 takes 1 CALC cycle and yields result 0.
- **Not defined:** CALC is always exactly N cycles, independent of data.
- Results are identical in both builds.

## Test plan
All scenarios use XLEN = 32, BITS_PER_CYCLE = 4.
- **Reset and clmul.** Reset, then clmul a = 0x00000003, b = 0x00000003 → result_o = 0x00000005. valid_o rises 9 cycles after acceptance (without the macro); ready_o = 1 and valid_o = 0 after reset.
- **All three operators.** a = 0x80000000, b = 0x80000000:
  - clmul → 0x00000000.
  - clmulh → 0x40000000.
  - clmulr → 0x80000000.
- **All-ones operands.** a = b = 0xFFFFFFFF: clmul → 0x55555555, clmulh → 0x55555555. Also clmul a = 0xFFFFFFFF, b = 1 → 0xFFFFFFFF.
- **Backpressure.**
  - Hold ready_i low for 5 cycles in DONE: valid_o and result_o stay stable and ready_o stays 0.
  - Raise ready_i: valid_o = 0 next cycle and ready_o = 1.
- **Kill.**
  - Assert kill_i in CALC cycle 3: IDLE next cycle, valid_o never rises.
  - kill_i together with valid_i in IDLE: no acceptance, busy_o stays 0.
- **Early exit (macro defined).** b = 0x00000005 → 1 CALC cycle; b = 0 → 1 CALC cycle with result 0; b = 0x80000000 → 8 CALC cycles.
